ex_flag_cond_stage: RTL and testbench

- Sits directly downstream of the 64-bit ALU adder in the EX stage of the pipelined ARM CPU.
- Consumes the adder's result and its N/Z/V/C flags.
- Holds the architectural NZCV flag register, which is updated only by flag-setting ops (ADDS/SUBS).
- Resolves B.cond and CBZ branch decisions, and registers result plus decision into the EX/MEM boundary with stall/flush handling.

---
 rtl/ex_flag_cond_stage.sv | 146 ++++++++++++++
 tb/tb_ex_flag_cond_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_flag_cond_stage.sv
// ex_flag_cond_stage
// EX-stage back end that sits after the 64-bit ALU adder. It holds the NZCV
// flag register, resolves B.cond / CBZ decisions and registers the result and
// decision into the EX/MEM boundary, with stall and flush handling.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   in_valid / in_ready  EX instruction handshake (in_ready = !stall, comb)
//   op                   00 ALU, 01 ALU set-flags, 10 B.cond, 11 CBZ
//   cond                 B.cond condition field
//   alu_result, alu_*    adder result and N/Z/V/C flags
//   stall, flush         downstream hold / kill of the EX instruction
//   out_valid            EX/MEM entry valid
//   out_result           registered ALU result
//   br_taken             registered branch decision
//   flags_q              NZCV register, packed {N,Z,C,V}
//
// Optional feature (macro BR_STATS_EN): adds br_count and br_taken_count,
// 32-bit wrapping counters of accepted branches and taken branches.
module ex_flag_cond_stage #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned COND_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        op,
   input  logic [COND_W-1:0] cond,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_neg,
   input  logic              alu_zero,
   input  logic              alu_ovf,
   input  logic              alu_cout,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_result,
   output logic              br_taken,
   output logic [3:0]        flags_q
`ifdef BR_STATS_EN
   ,
   output logic [31:0]       br_count,
   output logic [31:0]       br_taken_count
`endif
);

   localparam int unsigned FLAG_W = 4;
   localparam int unsigned CNT_W  = 32;

   localparam logic [1:0] OP_ALU  = 2'b00;
   localparam logic [1:0] OP_ALUS = 2'b01;
   localparam logic [1:0] OP_BCC  = 2'b10;
   localparam logic [1:0] OP_CBZ  = 2'b11;

   // A64 condition evaluation against {N,Z,C,V}; NV behaves as AL.
   function automatic logic cond_eval(input logic [COND_W-1:0] c,
                                      input logic [FLAG_W-1:0] f);
      logic n, z, cf, v;
      logic r;
      n  = f[3];
      z  = f[2];
      cf = f[1];
      v  = f[0];
      r  = 1'b1;
      case (c)
         4'b0000: r = z;
         4'b0001: r = ~z;
         4'b0010: r = cf;
         4'b0011: r = ~cf;
         4'b0100: r = n;
         4'b0101: r = ~n;
         4'b0110: r = v;
         4'b0111: r = ~v;
         4'b1000: r = cf & ~z;
         4'b1001: r = ~cf | z;
         4'b1010: r = (n == v);
         4'b1011: r = (n != v);
         4'b1100: r = ~z & (n == v);
         4'b1101: r = z | (n != v);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   logic              accept_c;
   logic              br_dec_c;
   logic [FLAG_W-1:0] flags_d;

   assign in_ready = ~stall;

   // Next flag value and branch decision for an accepted instruction.
   always_comb begin
      accept_c = in_valid & ~stall & ~flush;
      flags_d  = flags_q;
      br_dec_c = 1'b0;
      if (accept_c) begin
         case (op)
            OP_ALUS: flags_d  = {alu_neg, alu_zero, alu_cout, alu_ovf};
            OP_BCC:  br_dec_c = cond_eval(cond, flags_q);
            OP_CBZ:  br_dec_c = alu_zero;
            OP_ALU:  br_dec_c = 1'b0;
            default: br_dec_c = 1'b0;
         endcase
      end
   end

   // EX/MEM boundary and flag register; flush beats stall beats accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         br_taken   <= 1'b0;
         out_result <= '0;
         flags_q    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         br_taken  <= 1'b0;
      end else if (!stall) begin
         out_valid <= in_valid;
         br_taken  <= br_dec_c;
         flags_q   <= flags_d;
         if (in_valid) begin
            out_result <= alu_result;
         end
      end
   end

`ifdef BR_STATS_EN
   logic is_branch_c;
   assign is_branch_c = accept_c & op[1];

   // Branch statistics; natural 32-bit wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         br_count       <= '0;
         br_taken_count <= '0;
      end else if (is_branch_c) begin
         br_count <= br_count + CNT_W'(1);
         if (br_dec_c) begin
            br_taken_count <= br_taken_count + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_ex_flag_cond_stage.sv
// Directed bench for ex_flag_cond_stage with a behavioural reference model
// and a per-cycle compare process, plus literal pin checks.
module tb_ex_flag_cond_stage;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [3:0]  cond;
   logic [63:0] alu_result;
   logic        alu_neg, alu_zero, alu_ovf, alu_cout;
   logic        stall, flush;
   logic        out_valid;
   logic [63:0] out_result;
   logic        br_taken;
   logic [3:0]  flags_q;
`ifdef BR_STATS_EN
   logic [31:0] br_count, br_taken_count;
   int unsigned m_cnt, m_tcnt, base_cnt, base_tcnt;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state (values visible after the most recent edge)
   logic        m_valid, m_br;
   logic [63:0] m_res;
   logic [3:0]  m_flags;
   logic        chk_en = 1'b0;

   ex_flag_cond_stage dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .cond(cond), .alu_result(alu_result),
      .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_cout(alu_cout),
      .stall(stall), .flush(flush), .out_valid(out_valid), .out_result(out_result),
      .br_taken(br_taken), .flags_q(flags_q)
`ifdef BR_STATS_EN
      , .br_count(br_count), .br_taken_count(br_taken_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ARM-pseudocode style: base condition from cond[3:1], inverted by cond[0]
   // except for 1111.
   function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, r;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cf;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cf && !z;
         3'd5: r = (n == v);
         3'd6: r = (n == v) && !z;
         default: r = 1'b1;
      endcase
      if (c[0] && c != 4'hF) r = !r;
      return r;
   endfunction

   // Compare process: every negedge while enabled.
   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", 64'(out_valid), 64'(m_valid));
         check("br_taken", 64'(br_taken), 64'(m_br));
         check("out_result", out_result, m_res);
         check("flags_q", 64'(flags_q), 64'(m_flags));
         check("in_ready", 64'(in_ready), 64'(!stall));
`ifdef BR_STATS_EN
         check("br_count", 64'(br_count), 64'(m_cnt));
         check("br_taken_count", 64'(br_taken_count), 64'(m_tcnt));
`endif
      end
   end

   task automatic model_reset();
      m_valid = 1'b0; m_br = 1'b0; m_res = '0; m_flags = '0;
`ifdef BR_STATS_EN
      m_cnt = 0; m_tcnt = 0;
`endif
   endtask

   // One clock: drive inputs after the compare, predict, take the edge.
   task automatic drive(input logic v, input logic [1:0] o, input logic [3:0] c,
                        input logic [63:0] r, input logic [3:0] nzcv,
                        input logic st, input logic fl);
      logic        n_valid, n_br;
      logic [63:0] n_res;
      logic [3:0]  n_flags;
      logic        taken;
      @(negedge clk);
      #1;
      in_valid = v; op = o; cond = c; alu_result = r;
      {alu_neg, alu_zero, alu_cout, alu_ovf} = nzcv;
      stall = st; flush = fl;
      n_valid = m_valid; n_br = m_br; n_res = m_res; n_flags = m_flags;
      if (fl) begin
         n_valid = 1'b0; n_br = 1'b0;
      end else if (!st) begin
         if (v) begin
            taken = (o == 2'b10) ? model_cond(c, m_flags) :
                    (o == 2'b11) ? nzcv[2] : 1'b0;
            n_valid = 1'b1; n_res = r; n_br = taken;
            if (o == 2'b01) n_flags = nzcv;
`ifdef BR_STATS_EN
            if (o[1]) begin
               m_cnt++;
               if (taken) m_tcnt++;
            end
`endif
         end else begin
            n_valid = 1'b0; n_br = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      m_valid = n_valid; m_br = n_br; m_res = n_res; m_flags = n_flags;
   endtask

   task automatic idle();
      drive(1'b0, 2'b00, 4'h0, 64'h0, 4'h0, 1'b0, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 0; op = 0; cond = 0; alu_result = 0;
      alu_neg = 0; alu_zero = 0; alu_ovf = 0; alu_cout = 0; stall = 0; flush = 0;
      model_reset();
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk); #1 reset_n = 1'b1;

      // Set all flags, then drop reset mid-cycle during a stalled ADDS.
      drive(1'b1, 2'b01, 4'h0, 64'h1111, 4'b1111, 1'b0, 1'b0);
      check("pin_flags_1111", 64'(flags_q), 64'hF);
      @(negedge clk); #2;
      in_valid = 1; op = 2'b01; stall = 1; {alu_neg, alu_zero, alu_cout, alu_ovf} = 4'b0101;
      reset_n = 1'b0;
      #1;
      check("async_rst_flags", 64'(flags_q), 64'h0);
      check("async_rst_valid", 64'(out_valid), 64'h0);
      check("async_rst_br", 64'(br_taken), 64'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk); #1 reset_n = 1'b1;
      idle();

      // ADDS zero result with carry, then B.EQ / B.NE.
      drive(1'b1, 2'b01, 4'h0, 64'h0, 4'b0110, 1'b0, 1'b0);
      check("pin_adds_flags", 64'(flags_q), 64'h6);
      drive(1'b1, 2'b10, 4'b0000, 64'h20, 4'h0, 1'b0, 1'b0);
      check("pin_beq", 64'(br_taken), 64'h1);
      drive(1'b1, 2'b10, 4'b0001, 64'h24, 4'h0, 1'b0, 1'b0);
      check("pin_bne", 64'(br_taken), 64'h0);

      // Signed compare: N=1, V=0.
      drive(1'b1, 2'b01, 4'h0, 64'hFFFF_FFFF_FFFF_FFF0, 4'b1000, 1'b0, 1'b0);
      drive(1'b1, 2'b10, 4'b1011, 64'h30, 4'h0, 1'b0, 1'b0);
      check("pin_blt", 64'(br_taken), 64'h1);
      drive(1'b1, 2'b10, 4'b1010, 64'h34, 4'h0, 1'b0, 1'b0);
      check("pin_bge", 64'(br_taken), 64'h0);
      drive(1'b1, 2'b10, 4'b1100, 64'h38, 4'h0, 1'b0, 1'b0);
      check("pin_bgt", 64'(br_taken), 64'h0);

      // CBZ taken / not taken; flags untouched.
      drive(1'b1, 2'b11, 4'h0, 64'h0, 4'b0100, 1'b0, 1'b0);
      check("pin_cbz_taken", 64'(br_taken), 64'h1);
      check("pin_cbz_flags", 64'(flags_q), 64'h8);
      drive(1'b1, 2'b11, 4'h0, 64'h10, 4'b0000, 1'b0, 1'b0);
      check("pin_cbz_not", 64'(br_taken), 64'h0);
      check("pin_cbz_res", out_result, 64'h10);

      // ADDS held by stall for 3 cycles, then stall+flush together.
      repeat (3) drive(1'b1, 2'b01, 4'h0, 64'hDEAD, 4'b0011, 1'b1, 1'b0);
      check("pin_stall_flags", 64'(flags_q), 64'h8);
      check("pin_stall_res", out_result, 64'h10);
      drive(1'b1, 2'b01, 4'h0, 64'hBEEF, 4'b0011, 1'b1, 1'b1);
      check("pin_flush_valid", 64'(out_valid), 64'h0);
      check("pin_flush_flags", 64'(flags_q), 64'h8);
      drive(1'b1, 2'b00, 4'h0, 64'h5555, 4'b1111, 1'b0, 1'b0);
      check("pin_alu_noflags", 64'(flags_q), 64'h8);

      // Sweep every flag pattern against every condition code.
      for (int f = 0; f < 16; f++) begin
         drive(1'b1, 2'b01, 4'h0, 64'hA000 + 64'(f), 4'(f), 1'b0, 1'b0);
         for (int c = 0; c < 16; c++)
            drive(1'b1, 2'b10, 4'(c), 64'hB000 + 64'(c), 4'(15 - f), 1'b0, 1'b0);
         idle();
      end

      // Branch statistics segment: 5 accepted (3 taken), 1 flushed, 1 stalled.
`ifdef BR_STATS_EN
      base_cnt = m_cnt; base_tcnt = m_tcnt;
`endif
      drive(1'b1, 2'b01, 4'h0, 64'h0, 4'b0100, 1'b0, 1'b0);
      drive(1'b1, 2'b10, 4'b0000, 64'h1, 4'h0, 1'b0, 1'b0);
      drive(1'b1, 2'b10, 4'b0001, 64'h2, 4'h0, 1'b0, 1'b0);
      drive(1'b1, 2'b10, 4'b0000, 64'h3, 4'h0, 1'b0, 1'b1);
      drive(1'b1, 2'b11, 4'h0, 64'h0, 4'b0100, 1'b1, 1'b0);
      drive(1'b1, 2'b11, 4'h0, 64'h0, 4'b0100, 1'b0, 1'b0);
      drive(1'b1, 2'b11, 4'h0, 64'h7, 4'b0000, 1'b0, 1'b0);
      drive(1'b1, 2'b10, 4'b1110, 64'h8, 4'h0, 1'b0, 1'b0);
      idle();
`ifdef BR_STATS_EN
      check("pin_br_count", 64'(br_count - base_cnt), 64'd5);
      check("pin_br_taken_count", 64'(br_taken_count - base_tcnt), 64'd3);
`endif
      idle();

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
